// File: rtl/packet_injector_if.sv
// Router-facing handshake bundle: per-port packet data and valid from the injector,
// per-port ready back from the router.
interface packet_injector_if;
  logic [5:0]  valid;
  logic [5:0]  ready;
  logic [23:0] packet_out0;
  logic [23:0] packet_out1;
  logic [23:0] packet_out2;
  logic [23:0] packet_out3;
  logic [23:0] packet_out4;
  logic [23:0] packet_out5;

  modport master (
    output valid,
    output packet_out0,
    output packet_out1,
    output packet_out2,
    output packet_out3,
    output packet_out4,
    output packet_out5,
    input  ready
  );

  modport slave (
    input  valid,
    input  packet_out0,
    input  packet_out1,
    input  packet_out2,
    input  packet_out3,
    input  packet_out4,
    input  packet_out5,
    output ready
  );
endinterface

// File: rtl/packet_injector.sv
// Operator packet source: assembles six hex nibbles, queues {dest, packet} in a FIFO and
// presents the head packet on the matching router port with valid/ready.
module packet_injector #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       clear_n,
  input  logic [3:0]                 nibble_in,
  input  logic [2:0]                 dest,
  input  logic                       load,
  input  logic                       send,
  input  logic                       abort,
  packet_injector_if.master          bus,
  output logic [2:0]                 nibble_count,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       err
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [2:0]  NibFull = 3'd6;
  localparam logic [2:0]  MaxDest = 3'd5;

  logic            load_q, send_q;
  logic            load_rise, send_rise;
  logic [23:0]     asm_q, asm_d;
  logic [2:0]      nib_q, nib_d;
  logic            err_q, err_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [26:0]     mem [DEPTH];
  logic [26:0]     head;
  logic            full, empty, push, pop;
  logic [5:0]      valid_w;

  assign load_rise = load & ~load_q;
  assign send_rise = send & ~send_q;
  assign full      = (cnt_q == CntW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head      = mem[rd_ptr_q];

  // Assembler and commit; abort wins, then a send on a full assembler, then a load.
  always_comb begin
    asm_d = asm_q;
    nib_d = nib_q;
    err_d = err_q;
    push  = 1'b0;
    if (abort) begin
      asm_d = '0;
      nib_d = '0;
      err_d = 1'b0;
    end else if (send_rise && nib_q == NibFull) begin
      if (dest <= MaxDest && !full) begin
        push  = 1'b1;
        asm_d = '0;
        nib_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (load_rise && nib_q < NibFull) begin
      asm_d = {asm_q[19:0], nibble_in};
      nib_d = nib_q + 3'd1;
    end
  end

  // Valid depends only on registered FIFO state, never on ready.
  always_comb begin
    valid_w = '0;
    for (int i = 0; i < 6; i++) begin
      valid_w[i] = !empty && (head[26:24] == 3'(i));
    end
  end

  assign pop = |(valid_w & bus.ready);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      load_q   <= 1'b0;
      send_q   <= 1'b0;
      asm_q    <= '0;
      nib_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      load_q   <= load;
      send_q   <= send;
      asm_q    <= asm_d;
      nib_q    <= nib_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible while the count says occupied.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= {dest, asm_q};
    end
  end

  assign bus.valid       = valid_w;
  assign bus.packet_out0 = valid_w[0] ? head[23:0] : 24'h000000;
  assign bus.packet_out1 = valid_w[1] ? head[23:0] : 24'h000000;
  assign bus.packet_out2 = valid_w[2] ? head[23:0] : 24'h000000;
  assign bus.packet_out3 = valid_w[3] ? head[23:0] : 24'h000000;
  assign bus.packet_out4 = valid_w[4] ? head[23:0] : 24'h000000;
  assign bus.packet_out5 = valid_w[5] ? head[23:0] : 24'h000000;
  assign nibble_count    = nib_q;
  assign fifo_count      = cnt_q;
  assign err             = err_q;
endmodule

// File: tb/tb_packet_injector.sv
// Directed plus randomized bench for packet_injector, checked against a queue-based
// reference model of the operator/FIFO behaviour.
module tb_packet_injector;
  localparam int unsigned DEPTH = 4;

  logic       clock = 1'b0;
  logic       clear_n;
  logic [3:0] nibble_in;
  logic [2:0] dest;
  logic       load, send, abort;
  logic [2:0] nibble_count;
  logic [2:0] fifo_count;
  logic       err;

  packet_injector_if bus ();

  packet_injector #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .nibble_in   (nibble_in),
    .dest        (dest),
    .load        (load),
    .send        (send),
    .abort       (abort),
    .bus         (bus),
    .nibble_count(nibble_count),
    .fifo_count  (fifo_count),
    .err         (err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {dest, packet}, the partially entered packet, and flags.
  logic [26:0] mq[$];
  logic [23:0] m_asm;
  int          m_cnt;
  bit          m_err;
  bit          m_load_prev, m_send_prev;
  bit          rand_ready = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_asm       = '0;
    m_cnt       = 0;
    m_err       = 1'b0;
    m_load_prev = 1'b0;
    m_send_prev = 1'b0;
  endtask

  // One clock edge of operator-visible behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit lr, sr, was_full, do_pop;
    if (!clear_n) begin
      model_reset();
      return;
    end
    lr       = load && !m_load_prev;
    sr       = send && !m_send_prev;
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() > 0) && bus.ready[mq[0][26:24]];
    if (do_pop) void'(mq.pop_front());
    if (abort) begin
      m_asm = '0;
      m_cnt = 0;
      m_err = 1'b0;
    end else if (sr && m_cnt == 6) begin
      if (dest <= 5 && !was_full) begin
        mq.push_back({dest, m_asm});
        m_asm = '0;
        m_cnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (lr && m_cnt < 6) begin
      m_asm = m_asm * 16 + nibble_in;
      m_cnt++;
    end
    m_load_prev = load;
    m_send_prev = send;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] get_pkt(input int n);
    case (n)
      0: return bus.packet_out0;
      1: return bus.packet_out1;
      2: return bus.packet_out2;
      3: return bus.packet_out3;
      4: return bus.packet_out4;
      default: return bus.packet_out5;
    endcase
  endfunction

  task automatic check_all(input string ctx);
    logic [5:0]  ev;
    logic [23:0] ep;
    ev = '0;
    if (mq.size() > 0) ev[mq[0][26:24]] = 1'b1;
    chk({ctx, ".valid"}, bus.valid, ev);
    for (int n = 0; n < 6; n++) begin
      ep = (ev[n] && mq.size() > 0) ? mq[0][23:0] : 24'h0;
      chk($sformatf("%s.packet_out%0d", ctx, n), get_pkt(n), ep);
    end
    chk({ctx, ".nibble_count"}, nibble_count, m_cnt);
    chk({ctx, ".fifo_count"}, fifo_count, mq.size());
    chk({ctx, ".err"}, err, m_err);
  endtask

  task automatic tick(input string ctx = "tick");
    if (rand_ready) bus.ready = 6'($urandom);
    @(posedge clock);
    #1;
    model_step();
    check_all(ctx);
  endtask

  task automatic load_nibble(input logic [3:0] n);
    nibble_in = n;
    load      = 1'b1;
    tick("load");
    load = 1'b0;
    tick("load_low");
  endtask

  task automatic enter_packet(input logic [23:0] p);
    for (int i = 5; i >= 0; i--) load_nibble(p[4*i+:4]);
  endtask

  task automatic send_to(input logic [2:0] d);
    dest = d;
    send = 1'b1;
    tick("send");
    send = 1'b0;
    tick("send_low");
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick("abort");
    abort = 1'b0;
    tick("abort_low");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] p;
    clear_n   = 1'b0;
    nibble_in = '0;
    dest      = '0;
    load      = 1'b0;
    send      = 1'b0;
    abort     = 1'b0;
    bus.ready = '0;
    model_reset();
    tick("reset");
    tick("reset");
    chk("reset_valid", bus.valid, 6'b0);
    chk("reset_fifo", fifo_count, 0);
    chk("reset_nib", nibble_count, 0);
    chk("reset_err", err, 0);
    clear_n = 1'b1;
    tick("release");

    // Assemble 123456 and commit to port 2.
    for (int i = 1; i <= 6; i++) begin
      load_nibble(4'(i));
      chk("assemble_count", nibble_count, i);
    end
    send_to(3'd2);
    chk("commit_nib", nibble_count, 0);
    chk("commit_valid", bus.valid, 6'b000100);
    chk("commit_pkt2", bus.packet_out2, 24'h123456);
    chk("commit_pkt0", bus.packet_out0, 24'h0);

    // Ready on a non-selected port must not pop; the selected port pops.
    bus.ready = 6'b010000;
    tick("wrong_ready");
    tick("wrong_ready");
    chk("no_pop_fifo", fifo_count, 1);
    bus.ready = 6'b000100;
    tick("pop");
    chk("pop_fifo", fifo_count, 0);
    chk("pop_valid", bus.valid, 6'b0);
    bus.ready = '0;

    // Fill the FIFO, then a rejected fifth commit.
    for (int k = 0; k < 4; k++) begin
      enter_packet(24'($urandom));
      send_to(k == 0 ? 3'd0 : k == 1 ? 3'd1 : k == 2 ? 3'd3 : 3'd5);
    end
    chk("full_fifo", fifo_count, 4);
    enter_packet(24'($urandom));
    send_to(3'd2);
    chk("full_err", err, 1);
    chk("full_nib", nibble_count, 6);
    chk("full_fifo_kept", fifo_count, 4);
    bus.ready = 6'b000001;
    tick("pop_one");
    bus.ready = '0;
    send_to(3'd2);
    chk("retry_fifo", fifo_count, 4);
    chk("retry_err", err, 1);
    pulse_abort();
    chk("abort_err", err, 0);
    chk("abort_fifo", fifo_count, 4);
    bus.ready = 6'h3f;
    for (int i = 0; i < 6; i++) tick("drain");
    bus.ready = '0;

    // Illegal destination, early send, and an ignored seventh load.
    enter_packet(24'h0badf0);
    send_to(3'd7);
    chk("illegal_err", err, 1);
    chk("illegal_fifo", fifo_count, 0);
    pulse_abort();
    load_nibble(4'hA);
    load_nibble(4'hB);
    load_nibble(4'hC);
    send_to(3'd4);
    chk("early_send_nib", nibble_count, 3);
    chk("early_send_fifo", fifo_count, 0);
    load_nibble(4'hD);
    load_nibble(4'hE);
    load_nibble(4'hF);
    load_nibble(4'h9);
    chk("seventh_load_nib", nibble_count, 6);
    send_to(3'd4);
    chk("seventh_load_pkt", bus.packet_out4, 24'hABCDEF);
    bus.ready = 6'b010000;
    tick("pop4");
    bus.ready = '0;

    // Load held high: one shift only.
    nibble_in = 4'h5;
    load      = 1'b1;
    for (int i = 0; i < 10; i++) tick("load_held");
    load = 1'b0;
    tick("load_held_low");
    chk("load_held_nib", nibble_count, 1);
    pulse_abort();

    // Push and pop on the same edge with two entries queued.
    enter_packet(24'h111111);
    send_to(3'd0);
    enter_packet(24'h222222);
    send_to(3'd1);
    enter_packet(24'h333333);
    dest      = 3'd2;
    bus.ready = 6'h3f;
    send      = 1'b1;
    tick("push_pop");
    chk("push_pop_fifo", fifo_count, 2);
    send      = 1'b0;
    bus.ready = '0;
    tick("push_pop_low");
    chk("push_pop_head", bus.packet_out1, 24'h222222);

    // Random traffic with random ready, wrapping the pointers several times.
    rand_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      p = 24'($urandom);
      enter_packet(p);
      send_to(3'($urandom_range(0, 7)));
      if (m_err) pulse_abort();
      if (m_cnt != 0) pulse_abort();
    end
    rand_ready = 1'b0;
    bus.ready  = 6'h3f;
    for (int i = 0; i < 6; i++) tick("final_drain");
    bus.ready = '0;

    // Asynchronous reset between edges with a busy FIFO and partial assembler.
    for (int k = 0; k < 3; k++) begin
      enter_packet(24'($urandom));
      send_to(3'($urandom_range(0, 5)));
    end
    load_nibble(4'h1);
    load_nibble(4'h2);
    load_nibble(4'h3);
    load_nibble(4'h4);
    chk("pre_reset_fifo", fifo_count, 3);
    chk("pre_reset_nib", nibble_count, 4);
    #2;
    clear_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_valid", bus.valid, 6'b0);
    chk("async_reset_fifo", fifo_count, 0);
    chk("async_reset_nib", nibble_count, 0);
    chk("async_reset_pkt", bus.packet_out0 | bus.packet_out1 | bus.packet_out2 |
        bus.packet_out3 | bus.packet_out4 | bus.packet_out5, 24'h0);
    check_all("async_reset");
    tick("in_reset");
    clear_n = 1'b1;
    tick("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
